// File: rtl/booth_mul_arbiter_if.sv
// Bundle between requesters, the round-robin arbiter and the shared booth multiplier.
// The slave modport is the arbiter; the master modport is its environment (clients plus multiplier).
interface booth_mul_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] mcand;
  logic [8*N_REQ-1:0] mplier;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   res_valid;
  logic [15:0]        product;
  logic               err;
  logic               busy;
  logic               mul_enable;
  logic [7:0]         mul_inbus;
  logic               mul_done;
  logic [7:0]         mul_outbus;

  modport slave (
    input  req, mcand, mplier, mul_done, mul_outbus,
    output ack, res_valid, product, err, busy, mul_enable, mul_inbus
  );

  modport master (
    output req, mcand, mplier, mul_done, mul_outbus,
    input  ack, res_valid, product, err, busy, mul_enable, mul_inbus
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 signed booth multiplier between N_REQ clients.
// Optional WAIT-state timeout abort is enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mul_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  booth_mul_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
    $error("booth_mul_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_M,
    S_LOAD_Q,
    S_WAIT,
    S_READ_LO,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_winner;
  logic [IW-1:0]    r_lastGrant;
  logic [7:0]       r_mcand;
  logic [7:0]       r_mplier;
  logic [7:0]       r_prodHi;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_resValid;
  logic [15:0]      r_product;
  logic             r_busy;
  logic             r_mulEnable;
  logic [7:0]       r_mulInbus;

  logic             w_grantValid;
  logic [IW-1:0]    w_grantIdx;
  logic [IW:0]      w_scanIdx;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CW-1:0] r_waitCnt;
  logic          r_err;
`endif

  function automatic logic [N_REQ-1:0] oneHot(input logic [IW-1:0] idx);
    oneHot      = '0;
    oneHot[idx] = 1'b1;
  endfunction

  // Scan starts one past the last grant so the most recently served client ranks lowest.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_scanIdx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scanIdx = {1'b0, r_lastGrant} + (IW+1)'(k + 1);
      if (w_scanIdx >= (IW+1)'(N_REQ)) begin
        w_scanIdx = w_scanIdx - (IW+1)'(N_REQ);
      end
      if (!w_grantValid && bus.req[w_scanIdx[IW-1:0]]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_scanIdx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_winner    <= '0;
      r_lastGrant <= IW'(N_REQ - 1);
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_prodHi    <= '0;
      r_ack       <= '0;
      r_resValid  <= '0;
      r_product   <= '0;
      r_busy      <= 1'b0;
      r_mulEnable <= 1'b0;
      r_mulInbus  <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      r_waitCnt   <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_ack      <= '0;
      r_resValid <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_grantValid) begin
            r_winner <= w_grantIdx;
            r_mcand  <= bus.mcand[{w_grantIdx, 3'b000} +: 8];
            r_mplier <= bus.mplier[{w_grantIdx, 3'b000} +: 8];
            r_ack    <= oneHot(w_grantIdx);
            r_busy   <= 1'b1;
            r_state  <= S_LOAD_M;
          end
        end
        S_LOAD_M: begin
          r_mulEnable <= 1'b1;
          r_mulInbus  <= r_mcand;
          r_state     <= S_LOAD_Q;
        end
        S_LOAD_Q: begin
          r_mulEnable <= 1'b0;
          r_mulInbus  <= r_mplier;
`ifdef BOOTH_ARB_TIMEOUT_EN
          r_waitCnt   <= '0;
`endif
          r_state     <= S_WAIT;
        end
        // The A byte is on the result bus in the done cycle, the Q byte one cycle later.
        S_WAIT: begin
          r_mulInbus <= '0;
          if (bus.mul_done) begin
            r_prodHi <= bus.mul_outbus;
            r_state  <= S_READ_LO;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (r_waitCnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_err      <= 1'b1;
            r_resValid <= oneHot(r_winner);
            r_product  <= '0;
            r_state    <= S_RESP;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
`endif
        end
        S_READ_LO: begin
          r_product  <= {r_prodHi, bus.mul_outbus};
          r_resValid <= oneHot(r_winner);
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_lastGrant <= r_winner;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.res_valid  = r_resValid;
  assign bus.product    = r_product;
  assign bus.busy       = r_busy;
  assign bus.mul_enable = r_mulEnable;
  assign bus.mul_inbus  = r_mulInbus;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign bus.err        = r_err;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter that shares one `booth` sequential 8x8 signed multiplier between `N_REQ` requesters. It grants one requester at a time and streams that requester's multiplicand and multiplier onto the multiplier's 8-bit input bus. It then waits for completion, assembles the 16-bit product from the two result bytes, and returns it to the granted requester with a one-cycle valid pulse. It sits between client blocks and the multiplier, and is the only driver of the multiplier's `enable` and `inbus`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 64: cycles allowed in WAIT before abort. Used only with `BOOTH_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester request level; held until `ack`.
- `mcand`  in  8*N_REQ  signed multiplicand per requester; slice i is bits [8i+7:8i].
- `mplier`  in  8*N_REQ  signed multiplier per requester, same slicing.
- `ack`  out  N_REQ  one-hot one-cycle pulse; operands of that requester captured.
- `res_valid`  out  N_REQ  one-hot one-cycle pulse; product on `product` is valid.
- `product`  out  16  signed product {A byte, Q byte}.
- `err`  out  1  one-cycle pulse on timeout abort (0 when macro absent).
- `busy`  out  1  high in any state other than IDLE.
- `mul_enable`  out  1  start strobe to multiplier.
- `mul_inbus`  out  8  operand bus to multiplier.
- `mul_done`  in  1  multiplier completion.
- `mul_outbus`  in  8  multiplier result bus.

## Operation
- States: IDLE, LOAD_M, LOAD_Q, WAIT, READ_LO, RESP.
- IDLE: if any `req` is set, grant the first set bit at or after `last_grant+1` (mod N_REQ). Register the winner index, latch its `mcand` and `mplier` into local registers, pulse `ack[winner]`, and go to LOAD_M.
- LOAD_M: `mul_enable`=1 and `mul_inbus`=latched multiplicand for one cycle. Go to LOAD_Q.
- LOAD_Q: `mul_enable`=0 and `mul_inbus`=latched multiplier for one cycle. Go to WAIT.
- WAIT: `mul_inbus`=0. On the first cycle with `mul_done`=1, capture `mul_outbus` into the product high byte and go to READ_LO.
- READ_LO: capture `mul_outbus` into the product low byte. Go to RESP.
- RESP: drive `product`, pulse `res_valid[winner]`, set `last_grant`=winner, return to IDLE.
- Requests arriving during a transaction wait their turn. `req` is not sampled outside IDLE.
- Product is two's-complement: high byte is the multiplier's A register, low byte is its Q register. No saturation.
- Wrap-around: `last_grant`=N_REQ-1 searches from index 0.
- Simultaneous requests: the round-robin pointer decides. A requester that was just served has lowest priority next.
- `mul_done` asserted in LOAD_M or LOAD_Q is ignored.

## Timing
- Reset values: `ack`=0, `res_valid`=0, `product`=0, `err`=0, `busy`=0, `mul_enable`=0, `mul_inbus`=0, state=IDLE, `last_grant`=N_REQ-1 (first grant goes to index 0).
- `ack` is asserted 1 cycle after `req` is seen in IDLE.
- `mul_enable` is asserted the cycle after `ack`.
- Latency from `mul_done` to `res_valid` is 2 cycles.
- IDLE is re-entered the cycle after `res_valid`. Back-to-back grants are possible with one idle cycle between transactions.
- `rst` mid-transaction returns to IDLE next cycle. No `res_valid` or `ack` is issued.
- All outputs are registered.

## Configuration
- `BOOTH_ARB_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `mul_done`, pulse `err` and `res_valid[winner]` with `product`=16'h0000, then return to IDLE.
- `BOOTH_ARB_TIMEOUT_EN` undefined: no counter; WAIT waits indefinitely and `err` is tied to 0.

## Test plan
- Single requester: `req[0]`, mcand=8'd7, mplier=8'd6 -> `ack[0]`; `mul_inbus` shows 7 then 6; `res_valid[0]` with `product`=16'd42 two cycles after `mul_done`.
- Signed operands: mcand=-8'sd5, mplier=8'sd3 -> `product`=16'hFFF1. Also -128 x -128 -> 16'h4000.
- Simultaneous `req`=4'b1111, held after each ack -> grants in order 0,1,2,3,0; exactly one `res_valid` per grant.
- Wrap-around: last grant 3, then `req`=4'b1001 -> grant 0; next grant 3.
- `rst` asserted in WAIT -> next cycle `busy`=0, `mul_enable`=0, no `res_valid`; a new request is then served normally.
- With `BOOTH_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `mul_done` held 0 -> `err` and `res_valid` pulse with `product`=0 after 8 WAIT cycles; arbiter returns to IDLE.
